// File: rtl/ex_stage.sv
// ex_stage: MIPS EX stage ALU with an iterative 32-cycle mul/div unit and HI/LO registers.
// Define SIGNED_MULDIV_EN to add signed mult/div (funct 011000/011010).
module ex_stage #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] extend_immed,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [4:0]  wn,
  output logic [31:0] wd_store,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
  logic div_q, div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic is_r, is_mulu, is_divu, is_mul_s, is_div_s, is_div, sgn, start;
  logic [31:0] op_b, add_r, sub_r, slt_r, a_mag, b_mag;
  logic [32:0] sum, sh;
  logic [33:0] diff;
  logic [63:0] prod, neg_prod;
  assign is_r    = ALUOp == 2'b10;
  assign is_mulu = is_r && funct == 6'b011001;
  assign is_divu = is_r && funct == 6'b011011;
`ifdef SIGNED_MULDIV_EN
  assign is_mul_s = is_r && funct == 6'b011000;
  assign is_div_s = is_r && funct == 6'b011010;
`else
  assign is_mul_s = 1'b0;
  assign is_div_s = 1'b0;
`endif
  assign start = is_mulu || is_divu || is_mul_s || is_div_s;
  always_comb begin
    op_b = ALUSrc ? extend_immed : rd2;
    add_r = rd1 + op_b;
    sub_r = rd1 - op_b;
    slt_r = {31'd0, $signed(rd1) < $signed(op_b)};
    alu_result = ALUOp == 2'b01 ? sub_r :
                 ALUOp != 2'b10 ? add_r :
                 funct == 6'b100000 ? add_r :
                 funct == 6'b100010 ? sub_r :
                 funct == 6'b100100 ? (rd1 & op_b) :
                 funct == 6'b100101 ? (rd1 | op_b) :
                 funct == 6'b101010 ? slt_r :
                 funct == 6'b010000 ? hi_q :
                 funct == 6'b010010 ? lo_q : 32'd0;
    zero = alu_result == 32'd0;
    wn = RegDst ? rd : rt;
    wd_store = rd2;
    hi_out = hi_q;
    lo_out = lo_q;
  end
  // Signed ops iterate on magnitudes; the sign is restored when HI/LO are written.
  always_comb begin
    sgn = is_mul_s || is_div_s;
    is_div = is_divu || is_div_s;
    a_mag = (sgn && rd1[31]) ? -rd1 : rd1;
    b_mag = (sgn && rd2[31]) ? -rd2 : rd2;
    sum = {1'b0, acc_hi_q} + {1'b0, acc_lo_q[0] ? b_q : 32'd0};
    sh = {acc_hi_q, acc_lo_q[31]};
    diff = {1'b0, sh} - {2'b00, b_q};
    prod = {acc_hi_q, acc_lo_q};
    neg_prod = -prod;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q <= b_d;
      div_q <= div_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d = b_q;
    div_d = div_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d = '0;
        div_d = is_div;
        acc_hi_d = '0;
        acc_lo_d = is_div ? a_mag : b_mag;
        b_d = is_div ? b_mag : a_mag;
        neg_p_d = sgn && (rd1[31] ^ rd2[31]);
        neg_r_d = sgn && rd1[31];
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        {acc_hi_d, acc_lo_d} = div_q ? {diff[33] ? sh[31:0] : diff[31:0], acc_lo_q[30:0], ~diff[33]}
                                     : {sum, acc_lo_q[31:1]};
        state_d = cnt_q == CNT_W'(MD_CYCLES - 1) ? DONE : BUSY;
      end
      DONE: begin
        state_d = IDLE;
        hi_d = div_q ? (neg_r_q ? -acc_hi_q : acc_hi_q) : (neg_p_q ? neg_prod[63:32] : acc_hi_q);
        // A zero divisor keeps the all-ones quotient regardless of operand signs.
        lo_d = div_q ? ((neg_p_q && b_q != 32'd0) ? -acc_lo_q : acc_lo_q)
                     : (neg_p_q ? neg_prod[31:0] : acc_lo_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    stall = !rst && (state_q == BUSY || (state_q == IDLE && start));
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  ALUOp = '0;
  logic        ALUSrc = 1'b0, RegDst = 1'b0;
  logic [31:0] rd1 = '0, rd2 = '0, extend_immed = '0;
  logic [4:0]  rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [31:0] alu_result, wd_store, hi_out, lo_out;
  logic        zero, stall;
  logic [4:0]  wn;
  int checks = 0, errors = 0;
  localparam logic [5:0] MULTU = 6'b011001, DIVU = 6'b011011, MFHI = 6'b010000, MFLO = 6'b010010;
  ex_stage dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .rd1(rd1), .rd2(rd2), .extend_immed(extend_immed), .rt(rt), .rd(rd), .funct(funct),
    .alu_result(alu_result), .zero(zero), .wn(wn), .wd_store(wd_store), .stall(stall),
    .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [5:0] f);
    ALUOp = op;
    ALUSrc = src;
    rd1 = a;
    rd2 = b;
    extend_immed = imm;
    funct = f;
  endtask
  task automatic run_md(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f, input string tag);
    int n;
    n = 0;
    drive(2'b10, 1'b0, a, b, 32'd0, f);
    #1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk(tag, n, 33);
    @(negedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    rst = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 0);
    drive(2'b10, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 6'b101010);
    #1;
    chk("slt_res", alu_result, 1);
    chk("slt_zero", 32'(zero), 0);
    chk("slt_stall", 32'(stall), 0);
    drive(2'b01, 1'b0, 32'd5, 32'd5, 32'd0, 6'd0);
    #1;
    chk("beq_res", alu_result, 0);
    chk("beq_zero", 32'(zero), 1);
    chk("wd_store", wd_store, 5);
    RegDst = 1'b1; rt = 5'd3; rd = 5'd9;
    #1;
    chk("wn_rd", 32'(wn), 9);
    RegDst = 1'b0;
    #1;
    chk("wn_rt", 32'(wn), 3);
    drive(2'b00, 1'b1, 32'd10, 32'd77, 32'hFFFFFFFC, 6'd0);
    #1;
    chk("addi", alu_result, 6);
    drive(2'b10, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 6'b100100);
    #1;
    chk("and", alu_result, 32'h00F0_000F);
    funct = 6'b100101;
    #1;
    chk("or", alu_result, 32'hFFF0_0FFF);
    drive(2'b10, 1'b0, 32'd3, 32'd5, 32'd0, 6'b100010);
    #1;
    chk("sub_wrap", alu_result, 32'hFFFFFFFE);
    funct = 6'b100000;
    #1;
    chk("add_r", alu_result, 8);
    funct = 6'b111111;
    #1;
    chk("bad_funct", alu_result, 0);
    drive(2'b11, 1'b0, 32'd4, 32'd6, 32'd0, MULTU);
    #1;
    chk("aluop11_add", alu_result, 10);
    chk("aluop11_nostall", 32'(stall), 0);
    @(negedge clk);
    drive(2'b10, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, MULTU);
    #1;
    chk("multu_alu0", alu_result, 0);
    run_md(32'hFFFFFFFF, 32'd2, MULTU, "multu_stall_len");
    chk("multu_hi", hi_out, 1);
    chk("multu_lo", lo_out, 32'hFFFFFFFE);
    drive(2'b10, 1'b0, 32'd0, 32'd0, 32'd0, MFLO);
    #1;
    chk("mflo", alu_result, 32'hFFFFFFFE);
    chk("mflo_nostall", 32'(stall), 0);
    funct = MFHI;
    #1;
    chk("mfhi", alu_result, 1);
    @(negedge clk);
    #1;
    run_md(32'd100, 32'd7, DIVU, "divu_stall_len");
    chk("divu_lo", lo_out, 14);
    chk("divu_hi", hi_out, 2);
    run_md(32'd5, 32'd0, DIVU, "div0_stall_len");
    chk("div0_lo", lo_out, 32'hFFFFFFFF);
    chk("div0_hi", hi_out, 5);
    drive(2'b10, 1'b0, 32'd100, 32'd7, 32'd0, DIVU);
    #1;
    chk("rstmid_start", 32'(stall), 1);
    repeat (11) @(negedge clk);
    #1;
    chk("rstmid_busy", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("rst_forces_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0);
    #1;
    chk("rstmid_stall", 32'(stall), 0);
    chk("rstmid_hi", hi_out, 0);
    chk("rstmid_lo", lo_out, 0);
    @(negedge clk);
    #1;
    chk("rstmid_idle", 32'(stall), 0);
    run_md(32'd3, 32'd4, MULTU, "after_rst_len");
    chk("after_rst_hi", hi_out, 0);
    chk("after_rst_lo", lo_out, 12);
    drive(2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0);
    @(negedge clk);
    #1;
`ifdef SIGNED_MULDIV_EN
    run_md(32'hFFFFFFFD, 32'd5, 6'b011000, "mult_len");
    chk("mult_hi", hi_out, 32'hFFFFFFFF);
    chk("mult_lo", lo_out, 32'hFFFFFFF1);
    run_md(32'hFFFFFFF9, 32'd2, 6'b011010, "div_len");
    chk("div_lo", lo_out, 32'hFFFFFFFD);
    chk("div_hi", hi_out, 32'hFFFFFFFF);
    run_md(32'hFFFFFFF9, 32'd0, 6'b011010, "sdiv0_len");
    chk("sdiv0_lo", lo_out, 32'hFFFFFFFF);
    chk("sdiv0_hi", hi_out, 32'hFFFFFFF9);
`else
    drive(2'b10, 1'b0, 32'hFFFFFFFD, 32'd5, 32'd0, 6'b011000);
    #1;
    chk("mult_off_stall", 32'(stall), 0);
    chk("mult_off_alu", alu_result, 0);
    @(negedge clk);
    drive(2'b10, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 6'b011010);
    #1;
    chk("div_off_stall", 32'(stall), 0);
    @(negedge clk);
    #1;
    chk("off_stall", 32'(stall), 0);
    chk("off_hi", hi_out, 0);
    chk("off_lo", lo_out, 12);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
